// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side of the ALU operand/control interface.
// Accepts one MIPS-style instruction with its rs/rt values over a
// valid/ready handshake, decodes it into an ALU control code and operand B,
// drives the external combinational ALU, registers the result and returns it
// with zero/illegal flags over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid/in_ready        instruction handshake (ready only in IDLE)
//   in_instr, in_rs, in_rt   instruction word and register operands
//   alu_a, alu_b, alu_ctrl   registered operands/control to the ALU
//   alu_result               combinational ALU result
//   out_valid/out_ready      response handshake
//   out_result, out_zero, out_illegal  captured response
//   op_count                 saturating count of retired responses
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
  } req_t;

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_BAD = 4'b1111;

  state_t state;
  req_t   req;
  logic   illegal_q;

  // Decode view of the latched instruction
  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, imm_zext;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_b;
  logic        dec_ill;

  assign opcode   = req.instr[31:26];
  assign funct    = req.instr[5:0];
  assign imm_sext = {{16{req.instr[15]}}, req.instr[15:0]};
  assign imm_zext = {16'h0000, req.instr[15:0]};

  // Ready is purely a function of state so it reads 1 throughout reset.
  assign in_ready = (state == IDLE);

  always_comb begin
    dec_ctrl = C_BAD;
    dec_b    = req.rt;
    dec_ill  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   dec_ctrl = C_ADD;
          6'h22:   dec_ctrl = C_SUB;
          6'h24:   dec_ctrl = C_AND;
          6'h25:   dec_ctrl = C_OR;
          6'h27:   dec_ctrl = C_NOR;
          default: dec_ill  = 1'b1;
        endcase
      end
      6'h08, 6'h23, 6'h2B: begin
        dec_ctrl = C_ADD;
        dec_b    = imm_sext;
      end
      6'h0C: begin
        dec_ctrl = C_AND;
        dec_b    = imm_zext;
      end
      6'h0D: begin
        dec_ctrl = C_OR;
        dec_b    = imm_zext;
      end
      6'h04:   dec_ctrl = C_SUB;
      default: dec_ill  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req         <= '0;
      illegal_q   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= C_AND;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            req   <= '{instr: in_instr, rs: in_rs, rt: in_rt};
            state <= DECODE;
          end
        end
        DECODE: begin
          alu_a     <= req.rs;
          alu_b     <= dec_b;
          alu_ctrl  <= dec_ctrl;
          illegal_q <= dec_ill;
          state     <= EXEC;
        end
        EXEC: begin
          out_result  <= alu_result;
          out_zero    <= (alu_result == 32'h0);
          out_illegal <= illegal_q;
          out_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (op_count != {CNT_W{1'b1}})
              op_count <= op_count + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU closes the loop, and each
// transaction is checked against a reference computed directly from the
// instruction semantics. A second instance with a 2-bit counter shares all
// inputs to observe saturation.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [31:0] in_instr, in_rs, in_rt;
  logic [31:0] alu_a, alu_b, alu_a2, alu_b2;
  logic [3:0]  alu_ctrl, alu_ctrl2;
  logic [31:0] alu_result, alu_result2;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_result, out_result2;
  logic        out_zero, out_zero2, out_illegal, out_illegal2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;   // retired ops since last reset (unbounded)

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] c,
                                         input logic [31:0] a, b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result  = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_result2 = alu_fn(alu_ctrl2, alu_a2, alu_b2);

  alu_issue_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal),
    .op_count(op_count)
  );

  alu_issue_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_ctrl(alu_ctrl2),
    .alu_result(alu_result2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_result(out_result2), .out_zero(out_zero2), .out_illegal(out_illegal2),
    .op_count(op_count2)
  );

  // Instruction semantics straight from the ISA description.
  function automatic void ref_model(input logic [31:0] instr, rs, rt,
                                    output logic [31:0] res,
                                    output logic ill,
                                    output logic [3:0] ctrl);
    logic [5:0]  op, fn;
    logic [31:0] se, ze;
    op = instr[31:26];
    fn = instr[5:0];
    se = 32'($signed(instr[15:0]));
    ze = 32'(instr[15:0]);
    ill = 1'b0;
    res = 32'h0;
    ctrl = 4'b1111;
    if (op == 6'h00 && fn == 6'h20)      begin res = rs + rt;    ctrl = 4'b0010; end
    else if (op == 6'h00 && fn == 6'h22) begin res = rs - rt;    ctrl = 4'b0110; end
    else if (op == 6'h00 && fn == 6'h24) begin res = rs & rt;    ctrl = 4'b0000; end
    else if (op == 6'h00 && fn == 6'h25) begin res = rs | rt;    ctrl = 4'b0001; end
    else if (op == 6'h00 && fn == 6'h27) begin res = ~(rs | rt); ctrl = 4'b1100; end
    else if (op == 6'h08 || op == 6'h23 || op == 6'h2B)
                                         begin res = rs + se;    ctrl = 4'b0010; end
    else if (op == 6'h0C)                begin res = rs & ze;    ctrl = 4'b0000; end
    else if (op == 6'h0D)                begin res = rs | ze;    ctrl = 4'b0001; end
    else if (op == 6'h04)                begin res = rs - rt;    ctrl = 4'b0110; end
    else ill = 1'b1;
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] fn);
    return {6'h00, 20'h12345 & 20'hFFFFF, fn} ;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd3, 5'd4, imm};
  endfunction

  // One full transaction: issue, check latency, hold out_ready low for
  // 'stall' cycles (poking in_valid with junk), then retire and check.
  task automatic do_op(input string nm, input logic [31:0] instr, rs, rt,
                       input int stall);
    logic [31:0] e_res, hold_res;
    logic        e_ill;
    logic [3:0]  e_ctrl;
    ref_model(instr, rs, rt, e_res, e_ill, e_ctrl);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s in_ready before issue: got %b want 1", nm, in_ready);
    end
    in_valid = 1'b1; in_instr = instr; in_rs = rs; in_rt = rt;
    @(negedge clk);            // cycle N+1 (DECODE)
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s early: out_valid=%b in_ready=%b want 0/0", nm, out_valid, in_ready);
    end
    @(negedge clk);            // cycle N+2 (EXEC)
    n_cmp++;
    if (out_valid !== 1'b0 || alu_ctrl !== e_ctrl || alu_a !== rs) begin
      n_bad++;
      $display("FAIL %s exec: out_valid=%b alu_ctrl=%b alu_a=%h want 0/%b/%h",
               nm, out_valid, alu_ctrl, alu_a, e_ctrl, rs);
    end
    @(negedge clk);            // cycle N+3 (RESP)
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== e_res || out_zero !== (e_res == 0) ||
        out_illegal !== e_ill) begin
      n_bad++;
      $display("FAIL %s resp: v=%b res=%h z=%b ill=%b want 1/%h/%b/%b",
               nm, out_valid, out_result, out_zero, out_illegal, e_res, e_res == 0, e_ill);
    end
    hold_res = out_result;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_instr = 32'hFC00_0000; in_rs = 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== hold_res || in_ready !== 1'b0 ||
          alu_ctrl !== e_ctrl) begin
        n_bad++;
        $display("FAIL %s stall%0d: v=%b res=%h rdy=%b ctrl=%b want 1/%h/0/%b",
                 nm, i, out_valid, out_result, in_ready, alu_ctrl, hold_res, e_ctrl);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'(exp_cnt) ||
        op_count2 !== 2'((exp_cnt > 3) ? 3 : exp_cnt)) begin
      n_bad++;
      $display("FAIL %s retire: v=%b rdy=%b cnt=%0d cnt2=%0d want 0/1/%0d/%0d",
               nm, out_valid, in_ready, op_count, op_count2, exp_cnt,
               (exp_cnt > 3) ? 3 : exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs = '0; in_rt = '0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'h0 ||
        alu_ctrl !== 4'b0000 || alu_a !== 32'h0 || alu_b !== 32'h0 ||
        out_result !== 32'h0 || out_zero !== 1'b0 || out_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b v=%b cnt=%0d ctrl=%b a=%h b=%h res=%h z=%b ill=%b",
               in_ready, out_valid, op_count, alu_ctrl, alu_a, alu_b,
               out_result, out_zero, out_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_directed();
    do_op("add",  mk_r(6'h20), 32'd5, 32'd7, 0);
    do_op("beq",  mk_i(6'h04, 16'h0010), 32'h1234, 32'h1234, 0);
    do_op("addi", mk_i(6'h08, 16'hFFFF), 32'd1, 32'h55, 0);
    do_op("ori",  mk_i(6'h0D, 16'h8000), 32'd0, 32'h55, 0);
    do_op("andi", mk_i(6'h0C, 16'hFFFF), 32'hFFFF_1234, 32'h0, 0);
    do_op("lw",   mk_i(6'h23, 16'h8004), 32'h1000_0000, 32'h0, 0);
    do_op("sub",  mk_r(6'h22), 32'd3, 32'd10, 0);
  endtask

  task automatic test_backpressure();
    do_op("bp_or", mk_r(6'h25), 32'hF0F0_0000, 32'h0000_0F0F, 5);
    do_op("bp_next", mk_r(6'h24), 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
  endtask

  task automatic test_illegal();
    do_op("ill_op", mk_i(6'h3F, 16'h1234), 32'd9, 32'd9, 0);
    do_op("ill_fn", mk_r(6'h21), 32'd9, 32'd9, 1);
    do_op("nor",    mk_r(6'h27), 32'd0, 32'd0, 0);
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk_r(6'h20); in_rs = 32'd1; in_rt = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);            // EXEC
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== 16'h0 ||
        op_count2 !== 2'h0) begin
      n_bad++;
      $display("FAIL rst_mid: rdy=%b v=%b cnt=%0d cnt2=%0d want 1/0/0/0",
               in_ready, out_valid, op_count, op_count2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'h0) begin
        n_bad++;
        $display("FAIL rst_mid_after%0d: v=%b rdy=%b cnt=%0d want 0/1/0",
                 i, out_valid, in_ready, op_count);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [6];
    ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h04, 6'h3F, 6'h11};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(9)];
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(5)];
      do_op($sformatf("rnd%0d", k), ins, $urandom,
            ($urandom_range(3) == 0) ? 32'h0 : $urandom, $urandom_range(3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();      // 7 ops after reset also saturates the 2-bit counter
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a handshake wedges the bench.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Producer side of the ALU operand/control interface. Accepts one MIPS-style instruction plus register operands over a valid/ready handshake. Decodes opcode/funct into the 4-bit ALU control code and selects operand B (register or extended immediate). Drives the combinational ALU, registers its result, and returns the result with zero/illegal flags over a second valid/ready handshake. It sits between the decode/register-read stage and writeback in the multi-cycle datapath.

Parameters:
CNT_W, 16, width of the saturating retired-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction/operands valid
in_ready  output  1  block can accept an instruction
in_instr  input  32  instruction word; [31:26] opcode, [5:0] funct, [15:0] imm
in_rs  input  32  rs register value
in_rt  input  32  rt register value
alu_a  output  32  operand A to ALU
alu_b  output  32  operand B to ALU
alu_ctrl  output  4  ALU control code
alu_result  input  32  combinational result from ALU
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  32  captured ALU result
out_zero  output  1  out_result == 0
out_illegal  output  1  instruction not decodable
op_count  output  CNT_W  retired responses, saturating

Behaviour:
- Async reset (rst_n low), effective immediately. State=IDLE. alu_a, alu_b, out_result, op_count = 0. alu_ctrl = 4'b0000. out_valid, out_zero, out_illegal = 0. Latched instruction and operands are cleared.
- in_ready = 1 exactly when state==IDLE. This holds while reset is asserted.
- FSM IDLE -> DECODE -> EXEC -> RESP -> IDLE.
- IDLE: on in_valid&&in_ready, latch in_instr, in_rs and in_rt; go to DECODE. Otherwise stay.
- DECODE (1 cycle): register alu_a=rs, alu_b and alu_ctrl per the decode list below; go to EXEC.
- EXEC (1 cycle): capture alu_result into out_result; out_zero=(alu_result==0). Capture the illegal flag. Go to RESP.
- RESP: out_valid=1. out_result, out_zero and out_illegal are held stable until out_ready. On out_valid&&out_ready: out_valid=0, op_count+=1 (saturates at all-ones, never wraps), go to IDLE.
- Latency: handshake accepted in cycle N gives out_valid=1 in cycle N+3. Minimum issue interval is 4 cycles. in_valid while not IDLE is ignored; the input must be held by the producer.
- Decode, R-type (opcode 0x00), alu_b=rt:
  - funct 0x20 -> 0010 (add)
  - funct 0x22 -> 0110 (sub)
  - funct 0x24 -> 0000 (and)
  - funct 0x25 -> 0001 (or)
  - funct 0x27 -> 1100 (nor)
- Decode, other opcodes:
  - 0x08 addi -> 0010, alu_b = sign-extended imm
  - 0x23 lw / 0x2B sw -> 0010, alu_b = sign-extended imm
  - 0x0C andi -> 0000, alu_b = zero-extended imm
  - 0x0D ori -> 0001, alu_b = zero-extended imm
  - 0x04 beq -> 0110, alu_b = rt
- Any other opcode, or R-type with another funct: alu_ctrl=1111, alu_b=rt, illegal=1. The ALU default yields 0, so the response is out_result=0, out_zero=1, out_illegal=1. Illegal responses still count in op_count.
- Arithmetic is 32-bit modulo 2^32 (done in the ALU). No overflow flag.
- alu_a, alu_b and alu_ctrl stay stable from DECODE until the next DECODE.
- Reset asserted in any state aborts the operation. No response is produced, and the FSM returns to IDLE on deassertion.

Test Plan:
- Reset, then add: in_instr funct 0x20, rs=5, rt=7 -> out_valid 3 cycles after accept; out_result=12, out_zero=0, out_illegal=0, op_count=1.
- beq-style compare: opcode 0x04, rs=rt=0x1234 -> alu_ctrl=0110, out_result=0, out_zero=1.
- Immediate extension:
  - addi imm=0xFFFF, rs=1 -> out_result=0.
  - ori imm=0x8000, rs=0 -> out_result=0x00008000.
  - andi imm=0xFFFF, rs=0xFFFF1234 -> 0x00001234.
- Backpressure: out_ready low for 5 cycles in RESP -> out_valid and out_result stable, in_ready=0, a new in_valid is not accepted; accepted only after the response handshake.
- Illegal: opcode 0x3F -> alu_ctrl=1111, out_result=0, out_zero=1, out_illegal=1. nor funct 0x27 with rs=0, rt=0 -> 0xFFFFFFFF.
- Reset mid-EXEC -> out_valid never asserts, op_count=0, in_ready=1. A saturation check with CNT_W=2 over 5 ops -> op_count=3.
